game_state_publisher: RTL and testbench

Transmit side of the game-to-display state handoff. Runs in the 100 MHz `clk` domain. It samples the game-logic outputs once per 60 Hz game tick and buffers them. It then delivers each snapshot across to the VGA pixel domain using a 4-phase req/ack handshake, so the display receiver latches only complete, stable frames. It sits between `game_logic`/`map` and the VGA-domain snapshot receiver in `top`.

---
 rtl/game_state_pkg.sv | 45 ++++
 rtl/game_state_publisher_if.sv | 13 +
 rtl/game_state_publisher_sync_2ff.sv | 24 ++
 rtl/game_state_publisher.sv | 140 ++++++++++++++
 tb/tb_game_state_publisher.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_state_pkg.sv
// game_state_pkg: snapshot layout, reset constants and handshake FSM states shared by the
// publisher and the VGA-side snapshot receiver.
package game_state_pkg;

   localparam int N_OBS = 32'd10;

   localparam logic [9:0] OBS_X_RST    = 10'd700;
   localparam logic [8:0] OBS_Y_RST    = 9'd500;
   localparam logic [8:0] PLAYER_Y_RST = 9'd240;

   typedef logic [N_OBS-1:0][9:0] obs_x_t;
   typedef logic [N_OBS-1:0][8:0] obs_y_t;

   typedef struct packed {
      logic [1:0] gamemode;
      logic [8:0] player_y;
      obs_x_t     obs_xl;
      obs_x_t     obs_xr;
      obs_y_t     obs_yu;
      obs_y_t     obs_yd;
   } snapshot_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } pub_state_e;

   // Off-screen obstacles and a centred player: a safe frame to show before the first tick.
   function automatic snapshot_t snapshot_rst();
      snapshot_t s;
      s.gamemode = 2'd0;
      s.player_y = PLAYER_Y_RST;
      for (int i = 0; i < N_OBS; i++) begin
         s.obs_xl[i] = OBS_X_RST;
         s.obs_xr[i] = OBS_X_RST;
         s.obs_yu[i] = OBS_Y_RST;
         s.obs_yd[i] = OBS_Y_RST;
      end
      return s;
   endfunction

   localparam snapshot_t SNAPSHOT_RST = snapshot_rst();

endpackage

// File: rtl/game_state_publisher_if.sv
// game_state_publisher_if: 4-phase req/ack snapshot channel between the game clock domain
// and the VGA pixel domain.
interface game_state_publisher_if;
   import game_state_pkg::*;

   logic      pub_req;
   snapshot_t pub_data;
   logic      pub_ack;

   modport master (output pub_req, output pub_data, input pub_ack);
   modport slave  (input pub_req, input pub_data, output pub_ack);

endinterface

// File: rtl/game_state_publisher_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;
   logic sync_q;

   // Two flops in series give the first stage a full cycle to resolve metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/game_state_publisher.sv
// game_state_publisher: captures game state on each falling 60 Hz tick and delivers it to the
// VGA domain over 4-phase req/ack. PUB_DROP_CNT_EN compiles in the overwritten-snapshot counter.
module game_state_publisher
   import game_state_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n_debounced,
   input  logic                   tick_60hz,
   input  logic [1:0]             gamemode,
   input  logic [8:0]             player_y,
   input  logic [N_OBS-1:0][9:0]  obstacle_x_left,
   input  logic [N_OBS-1:0][9:0]  obstacle_x_right,
   input  logic [N_OBS-1:0][8:0]  obstacle_y_up,
   input  logic [N_OBS-1:0][8:0]  obstacle_y_down,
   game_state_publisher_if.master pub_if,
   output logic                   busy,
   output logic [7:0]             drop_cnt
);
   pub_state_e state_q, state_d;
   logic       tick_s, tick_q, cap_s, ack_s;
   logic       pend_valid_q, pend_valid_d;
   logic       req_q, req_d;
   logic       busy_q, busy_d;
   snapshot_t  pend_buf_q, pend_buf_d;
   snapshot_t  data_q, data_d;
   snapshot_t  cur_snap_s;

   sync_2ff u_tick_sync (.clk(clk), .rst_n(rst_n_debounced), .d_i(tick_60hz),      .q_o(tick_s));
   sync_2ff u_ack_sync  (.clk(clk), .rst_n(rst_n_debounced), .d_i(pub_if.pub_ack), .q_o(ack_s));

   // Game logic moves on the rising tick, so the falling edge samples settled inputs.
   assign cap_s      = tick_q & ~tick_s;
   assign cur_snap_s = {gamemode, player_y, obstacle_x_left, obstacle_x_right,
                        obstacle_y_up, obstacle_y_down};

   // Handshake FSM next state plus the pending-buffer update.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      data_d       = data_q;
      pend_buf_d   = pend_buf_q;
      pend_valid_d = pend_valid_q;
      case (state_q)
         IDLE: begin
            if (pend_valid_q) begin
               data_d       = pend_buf_q;
               pend_valid_d = 1'b0;
               req_d        = 1'b1;
               state_d      = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REL;
            end else begin
               state_d = REQ;
            end
         end
         REL: begin
            if (!ack_s) begin
               state_d = IDLE;
            end else begin
               state_d = REL;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
      // A capture in the load cycle lands after the load, so the old buffer is what gets sent.
      if (cap_s) begin
         pend_buf_d   = cur_snap_s;
         pend_valid_d = 1'b1;
      end else begin
         pend_buf_d = pend_buf_q;
      end
      busy_d = (state_d != IDLE);
   end

   // State, buffers and handshake outputs; reset also drops req mid-transfer as an abort.
   always_ff @(posedge clk or negedge rst_n_debounced) begin
      if (!rst_n_debounced) begin
         state_q      <= IDLE;
         tick_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_buf_q   <= SNAPSHOT_RST;
         data_q       <= SNAPSHOT_RST;
         req_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_s;
         pend_valid_q <= pend_valid_d;
         pend_buf_q   <= pend_buf_d;
         data_q       <= data_d;
         req_q        <= req_d;
         busy_q       <= busy_d;
      end
   end

`ifdef PUB_DROP_CNT_EN
   logic       load_s, drop_s;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   assign load_s = (state_q == IDLE) & pend_valid_q;
   assign drop_s = cap_s & pend_valid_q & ~load_s;

   // Saturating count of pending snapshots overwritten before they could be sent.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_s && (drop_cnt_q != 8'd255)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n_debounced) begin
      if (!rst_n_debounced) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

   assign pub_if.pub_req  = req_q;
   assign pub_if.pub_data = data_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_game_state_publisher.sv
// tb_game_state_publisher: randomized self-checking bench with a queue-based delivery model.
`timescale 1ns/1ps
module tb_game_state_publisher;
   import game_state_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n_debounced;
   logic                  tick_60hz;
   logic [1:0]            gamemode;
   logic [8:0]            player_y;
   logic [N_OBS-1:0][9:0] obstacle_x_left, obstacle_x_right;
   logic [N_OBS-1:0][8:0] obstacle_y_up, obstacle_y_down;
   logic                  busy;
   logic [7:0]            drop_cnt;

   int errors = 0;
   int checks = 0;

`ifdef PUB_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   game_state_publisher_if pub_if ();

   game_state_publisher dut (
      .clk              (clk),
      .rst_n_debounced  (rst_n_debounced),
      .tick_60hz        (tick_60hz),
      .gamemode         (gamemode),
      .player_y         (player_y),
      .obstacle_x_left  (obstacle_x_left),
      .obstacle_x_right (obstacle_x_right),
      .obstacle_y_up    (obstacle_y_up),
      .obstacle_y_down  (obstacle_y_down),
      .pub_if           (pub_if),
      .busy             (busy),
      .drop_cnt         (drop_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- responder / monitor ----------------
   bit        resp_en  = 1'b0;
   int        resp_dly = 5;
   logic      resp_ack = 1'b0;
   logic      man_ack  = 1'b0;
   snapshot_t got_q[$];
   int        req_rises = 0;
   int        unstable  = 0;

   assign pub_if.pub_ack = resp_en ? resp_ack : man_ack;

   initial begin
      snapshot_t hold;
      bit watching = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
      int rcnt = 0;
      hold = '0;
      forever begin
         @(negedge clk);
         if (!rst_n_debounced) begin
            watching = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; rcnt = 0; resp_ack = 1'b0;
         end else begin
            if (pub_if.pub_req && !prev_req) begin
               got_q.push_back(pub_if.pub_data);
               hold = pub_if.pub_data;
               watching = 1'b1;
               req_rises++;
            end
            if (watching && (pub_if.pub_data !== hold)) unstable++;
            if (watching && prev_ack && !pub_if.pub_ack) watching = 1'b0;
            prev_req = pub_if.pub_req;
            prev_ack = pub_if.pub_ack;
            if (resp_en && pub_if.pub_req && !resp_ack) begin
               rcnt++;
               if (rcnt >= resp_dly) begin resp_ack = 1'b1; rcnt = 0; end
            end else if (resp_en && !pub_if.pub_req && resp_ack) begin
               rcnt++;
               if (rcnt >= resp_dly) begin resp_ack = 1'b0; rcnt = 0; end
            end else begin
               rcnt = 0;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   snapshot_t exp_q[$];
   snapshot_t mdl_pend;
   bit        mdl_pend_v = 1'b0;
   bit        mdl_busy   = 1'b0;
   int        mdl_drops  = 0;

   function automatic void mdl_reset();
      exp_q.delete(); mdl_pend_v = 1'b0; mdl_busy = 1'b0; mdl_drops = 0;
   endfunction

   function automatic void mdl_capture(input snapshot_t s);
      if (!mdl_busy) begin
         exp_q.push_back(s); mdl_busy = 1'b1;
      end else begin
         if (mdl_pend_v && mdl_drops < 255) mdl_drops++;
         mdl_pend = s; mdl_pend_v = 1'b1;
      end
   endfunction

   function automatic void mdl_done();
      if (mdl_pend_v) begin exp_q.push_back(mdl_pend); mdl_pend_v = 1'b0; end
      else mdl_busy = 1'b0;
   endfunction

   function automatic logic [7:0] exp_drop();
      return DROP_EN ? 8'(mdl_drops) : 8'd0;
   endfunction

   function automatic snapshot_t rst_snap();
      snapshot_t s;
      s.gamemode = 2'd0;
      s.player_y = 9'd240;
      for (int i = 0; i < N_OBS; i++) begin
         s.obs_xl[i] = 10'd700; s.obs_xr[i] = 10'd700;
         s.obs_yu[i] = 9'd500;  s.obs_yd[i] = 9'd500;
      end
      return s;
   endfunction

   function automatic snapshot_t cur_snap();
      snapshot_t s;
      s.gamemode = gamemode;        s.player_y = player_y;
      s.obs_xl   = obstacle_x_left; s.obs_xr   = obstacle_x_right;
      s.obs_yu   = obstacle_y_up;   s.obs_yd   = obstacle_y_down;
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      gamemode = 2'($urandom_range(0, 3));
      player_y = 9'($urandom_range(0, 511));
      for (int i = 0; i < N_OBS; i++) begin
         obstacle_x_left[i]  = 10'($urandom_range(0, 1023));
         obstacle_x_right[i] = 10'($urandom_range(0, 1023));
         obstacle_y_up[i]    = 9'($urandom_range(0, 511));
         obstacle_y_down[i]  = 9'($urandom_range(0, 511));
      end
   endtask

   task automatic tick_fall();
      tick_60hz = 1'b1; cyc(4);
      tick_60hz = 1'b0; cyc(8);
   endtask

   task automatic wait_for(input int n, input int budget, input string tag);
      int k = 0;
      while (!(got_q.size() >= n && !busy && !pub_if.pub_ack) && k < budget) begin cyc(1); k++; end
      checks++;
      if (k >= budget) begin
         errors++;
         $display("FAIL %s: timeout, transfers=%0d required=%0d", tag, got_q.size(), n);
      end
   endtask

   task automatic manual_handshake(input string tag);
      int k = 0;
      bit to = 1'b0;
      while (!pub_if.pub_req && k < 30) begin cyc(1); k++; end
      if (k >= 30) to = 1'b1;
      @(negedge clk); man_ack = 1'b1;
      k = 0;
      while (pub_if.pub_req && k < 30) begin cyc(1); k++; end
      if (k >= 30) to = 1'b1;
      cyc(2);
      @(negedge clk); man_ack = 1'b0;
      cyc(5);
      checks++;
      if (to) begin errors++; $display("FAIL %s: handshake timeout, req=%b", tag, pub_if.pub_req); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      snapshot_t rs;
      rs = rst_snap();
      rst_n_debounced = 1'b1; #2;
      rst_n_debounced = 1'b0; cyc(3);
      checks++; if (pub_if.pub_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", pub_if.pub_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      checks++; if (pub_if.pub_data !== rs) begin errors++; $display("FAIL reset_data: got %h want %h", pub_if.pub_data, rs); end
      checks++; if (pub_if.pub_data.player_y !== 9'd240) begin errors++; $display("FAIL reset_player_y: got %0d want 240", pub_if.pub_data.player_y); end
      rst_n_debounced = 1'b1; cyc(4);
      checks++; if (pub_if.pub_req !== 1'b0) begin errors++; $display("FAIL post_reset_req: got %b want 0", pub_if.pub_req); end
   endtask

   task automatic test_single();
      snapshot_t s;
      int r0, lat;
      got_q.delete(); exp_q.delete();
      resp_en = 1'b1; resp_dly = 5; r0 = req_rises;
      rand_inputs(); player_y = 9'd100; gamemode = 2'd1;
      s = cur_snap(); mdl_capture(s);
      tick_60hz = 1'b1; cyc(4);
      tick_60hz = 1'b0; lat = 0;
      while (!pub_if.pub_req && lat < 10) begin cyc(1); lat++; end
      checks++; if (lat > 5) begin errors++; $display("FAIL single_latency: got %0d cycles want <=5", lat); end
      wait_for(1, 150, "single_done");
      mdl_done();
      checks++; if (req_rises - r0 != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", req_rises - r0); end
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h want %h", got_q[0], exp_q[0]); end
      checks++; if (got_q[0].player_y !== 9'd100) begin errors++; $display("FAIL single_player_y: got %0d want 100", got_q[0].player_y); end
      checks++; if (got_q[0].gamemode !== 2'd1) begin errors++; $display("FAIL single_mode: got %0d want 1", got_q[0].gamemode); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
      checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL single_drop: got %0d want %0d", drop_cnt, exp_drop()); end
   endtask

   task automatic test_overrun();
      int vals[3] = '{10, 20, 30};
      snapshot_t s;
      int r0;
      got_q.delete(); exp_q.delete();
      resp_en = 1'b0; man_ack = 1'b0; r0 = req_rises;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); player_y = 9'(vals[i]);
         s = cur_snap(); mdl_capture(s);
         tick_fall(); cyc(4);
      end
      checks++; if (req_rises - r0 != 1) begin errors++; $display("FAIL overrun_stuck_pulses: got %0d want 1", req_rises - r0); end
      checks++; if (pub_if.pub_data.player_y !== 9'd10) begin errors++; $display("FAIL overrun_stuck_data: got %0d want 10", pub_if.pub_data.player_y); end
      checks++; if (drop_cnt !== (DROP_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL overrun_drop: got %0d want %0d", drop_cnt, DROP_EN ? 1 : 0); end
      resp_en = 1'b1; resp_dly = 5;
      wait_for(2, 200, "overrun_release");
      mdl_done(); mdl_done();
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL overrun_count: got %0d want 2", got_q.size()); end
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL overrun_first: got %h want %h", got_q[0], exp_q[0]); end
      checks++; if (got_q[1] !== exp_q[1]) begin errors++; $display("FAIL overrun_second: got %h want %h", got_q[1], exp_q[1]); end
      checks++; if (got_q[1].player_y !== 9'd30) begin errors++; $display("FAIL overrun_latest: got %0d want 30", got_q[1].player_y); end
      checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL overrun_drop_final: got %0d want %0d", drop_cnt, exp_drop()); end
   endtask

   task automatic test_stability();
      snapshot_t s;
      int r0, u0;
      got_q.delete(); exp_q.delete();
      resp_en = 1'b1; r0 = req_rises; u0 = unstable;
      for (int it = 0; it < 12; it++) begin
         resp_dly = $urandom_range(1, 8);
         rand_inputs(); s = cur_snap(); mdl_capture(s);
         tick_fall();
         repeat (40) begin rand_inputs(); cyc(1); end
         mdl_done();
      end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stab_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stab_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (unstable != u0) begin errors++; $display("FAIL stab_unstable: got %0d changes want 0", unstable - u0); end
      checks++; if (req_rises - r0 != 12) begin errors++; $display("FAIL stab_pulses: got %0d want 12", req_rises - r0); end
      checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL stab_drop: got %0d want %0d", drop_cnt, exp_drop()); end
   endtask

   task automatic test_simultaneous();
      snapshot_t a, b, c;
      logic [7:0] d0;
      int k;
      got_q.delete(); exp_q.delete();
      resp_en = 1'b0; man_ack = 1'b0;
      rand_inputs(); player_y = 9'd50; a = cur_snap(); mdl_capture(a); tick_fall(); cyc(4);
      rand_inputs(); player_y = 9'd60; b = cur_snap(); mdl_capture(b); tick_fall(); cyc(4);
      rand_inputs(); player_y = 9'd70; c = cur_snap();
      d0 = drop_cnt;
      tick_60hz = 1'b1; cyc(4);
      @(negedge clk); man_ack = 1'b1;
      k = 0;
      while (pub_if.pub_req && k < 30) begin cyc(1); k++; end
      checks++; if (k >= 30) begin errors++; $display("FAIL simul_req_fall: timeout req=%b", pub_if.pub_req); end
      cyc(2);
      // Tick lowered one cycle after ack so both synchronizers deliver it in the IDLE load cycle.
      @(negedge clk); man_ack = 1'b0;
      @(negedge clk); tick_60hz = 1'b0;
      mdl_done(); mdl_capture(c);
      cyc(8);
      checks++; if (drop_cnt !== d0) begin errors++; $display("FAIL simul_drop_same: got %0d want %0d", drop_cnt, d0); end
      checks++; if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL simul_drop_model: got %0d want %0d", drop_cnt, exp_drop()); end
      checks++; if (pub_if.pub_data !== b) begin errors++; $display("FAIL simul_old_sent: got %h want %h", pub_if.pub_data, b); end
      manual_handshake("simul_hs_b"); mdl_done();
      manual_handshake("simul_hs_c"); mdl_done();
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL simul_count: got %0d want 3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (got_q[2].player_y !== 9'd70) begin errors++; $display("FAIL simul_new_pending: got %0d want 70", got_q[2].player_y); end
   endtask

   task automatic test_reset_mid();
      snapshot_t s;
      int r0;
      got_q.delete(); exp_q.delete();
      resp_en = 1'b0; man_ack = 1'b0;
      rand_inputs(); tick_fall(); cyc(2);
      checks++; if (pub_if.pub_req !== 1'b1) begin errors++; $display("FAIL mid_in_req: got %b want 1", pub_if.pub_req); end
      #2 rst_n_debounced = 1'b0;
      #1;
      checks++; if (pub_if.pub_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", pub_if.pub_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (pub_if.pub_data !== rst_snap()) begin errors++; $display("FAIL mid_data: got %h want %h", pub_if.pub_data, rst_snap()); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_cnt); end
      cyc(2); rst_n_debounced = 1'b1; cyc(3);
      mdl_reset(); got_q.delete();
      resp_en = 1'b1; resp_dly = 3; r0 = req_rises;
      rand_inputs(); s = cur_snap(); mdl_capture(s);
      tick_fall();
      wait_for(1, 150, "mid_after");
      mdl_done();
      checks++; if (req_rises - r0 != 1) begin errors++; $display("FAIL mid_pulses: got %0d want 1", req_rises - r0); end
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_data_after: got %h want %h", got_q[0], exp_q[0]); end
   endtask

   initial begin
      rst_n_debounced = 1'b1;
      tick_60hz = 1'b0;
      rand_inputs();
      test_reset();
      test_single();
      test_overrun();
      test_stability();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
